// File: rtl/gpu_pkg.sv
// Shared GPU definitions: writeback FSM states, register map and status codes.
package gpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WRITE,
        ST_INTERRUPT,
        ST_ERROR
    } wb_state_e;

    localparam logic [3:0] REG_BASE     = 4'h0;
    localparam logic [3:0] REG_START    = 4'h1;
    localparam logic [3:0] REG_COUNT    = 4'h2;
    localparam logic [3:0] REG_GO       = 4'h3;
    localparam logic [3:0] REG_PROGRESS = 4'h4;
    localparam logic [3:0] REG_STATUS   = 4'hF;

    localparam logic [31:0] STATUS_IDLE  = 32'd0;
    localparam logic [31:0] STATUS_BUSY  = 32'd1;
    localparam logic [31:0] STATUS_ERROR = 32'd2;

    // Scale by a constant using shifted adds only; with a constant k this
    // collapses to a small adder tree instead of a multiplier.
    function automatic logic [31:0] scale_const(input logic [31:0] v, input int unsigned k);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (k[i]) begin
                acc = acc + (v << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/pixel_addr_gen.sv
// Framebuffer address generator: locates START as row/column by repeated
// subtraction, then walks the pixel address with column wrap onto the next row.
module pixel_addr_gen
    import gpu_pkg::*;
#(
    parameter int H_RESOLUTION = 320,
    parameter int PIXEL_BYTES  = 2,
    parameter int ROW_STRIDE   = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_i,       // capture BASE/START for a new pass
    input  logic [31:0] base_i,
    input  logic [31:0] start_i,
    input  logic        step_i,       // one SETUP iteration
    input  logic        advance_i,    // one pixel accepted by the bus
    output logic        setup_done_o, // remainder is now the column
    output logic [31:0] addr_o
);

    localparam int COL_W = (H_RESOLUTION > 1) ? $clog2(H_RESOLUTION) : 1;
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(H_RESOLUTION - 1);
    localparam logic [31:0]      H_RES32   = 32'(H_RESOLUTION);
    localparam logic [31:0]      STRIDE32  = 32'(ROW_STRIDE);
    localparam logic [31:0]      PB32      = 32'(PIXEL_BYTES);
    // Moving START down one row swaps H_RESOLUTION pixels of column offset
    // for one row stride; wraps modulo 2^32 when the stride is smaller.
    localparam logic [31:0]      ROW_SKEW  = 32'(ROW_STRIDE - H_RESOLUTION * PIXEL_BYTES);

    // Row position is carried as its byte address (rowaddr), so no separate
    // row index is needed.
    logic [31:0]      rem_q, rem_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [31:0]      rowaddr_q, rowaddr_d;
    logic [31:0]      pixaddr_q, pixaddr_d;

    assign setup_done_o = (rem_q < H_RES32);
    assign addr_o       = pixaddr_q;

    // Next-state for the counters: load, subtract-a-row, or step one pixel.
    always_comb begin
        rem_d     = rem_q;
        col_d     = col_q;
        rowaddr_d = rowaddr_q;
        pixaddr_d = pixaddr_q;
        if (load_i) begin
            rem_d     = start_i;
            col_d     = '0;
            rowaddr_d = base_i;
            pixaddr_d = base_i + scale_const(start_i, PIXEL_BYTES);
        end else if (step_i) begin
            if (rem_q >= H_RES32) begin
                rem_d     = rem_q - H_RES32;
                rowaddr_d = rowaddr_q + STRIDE32;
                pixaddr_d = pixaddr_q + ROW_SKEW;
            end else begin
                col_d = rem_q[COL_W-1:0];
            end
        end else if (advance_i) begin
            if (col_q == COL_LAST) begin
                col_d     = '0;
                rowaddr_d = rowaddr_q + STRIDE32;
                pixaddr_d = rowaddr_q + STRIDE32;
            end else begin
                col_d     = col_q + 1'b1;
                pixaddr_d = pixaddr_q + PB32;
            end
        end
    end

    // Counter registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            rem_q     <= '0;
            col_q     <= '0;
            rowaddr_q <= '0;
            pixaddr_q <= '0;
        end else begin
            rem_q     <= rem_d;
            col_q     <= col_d;
            rowaddr_q <= rowaddr_d;
            pixaddr_q <= pixaddr_d;
        end
    end

endmodule

// File: rtl/pixel_writeback.sv
// Pixel writeback engine: CPU register file and control FSM that streams
// shader results into a framebuffer region through a write master.
module pixel_writeback
    import gpu_pkg::*;
#(
    parameter int H_RESOLUTION = 320,
    parameter int V_RESOLUTION = 240,
    parameter int NUM_SHADERS  = 320,
    parameter int PIXEL_BITS   = 16,
    parameter int PIXEL_BYTES  = 2,
    parameter int ROW_STRIDE   = 1024,
    localparam int PIX_IDX_W   = (NUM_SHADERS > 1) ? $clog2(NUM_SHADERS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            s1_address,
    input  logic                  s1_read,
    input  logic                  s1_write,
    input  logic [31:0]           s1_writedata,
    output logic [31:0]           s1_readdata,
    output logic                  s1_waitrequest,
    output logic                  irq,
    output logic [PIX_IDX_W-1:0]  pix_index,
    input  logic [PIXEL_BITS-1:0] pix_data,
    output logic [31:0]           m1_address,
    output logic [PIXEL_BITS-1:0] m1_writedata,
    output logic                  m1_write,
    input  logic                  m1_waitrequest
);

    localparam logic [31:0] NS32    = 32'(NUM_SHADERS);
    localparam logic [32:0] FRAME33 = 33'(H_RESOLUTION * V_RESOLUTION);

    wb_state_e   state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [31:0] start_q, start_d;
    logic [31:0] count_q, count_d;
    logic [31:0] progress_q, progress_d;

    logic        busy;
    logic        go_wr;
    logic        go_start;
    logic        go_valid;
    logic        status_rd;
    logic        status_clr;
    logic        accept;
    logic        last_pixel;
    logic        setup_done;
    logic [31:0] pix_addr;

    assign busy       = (state_q == ST_SETUP) || (state_q == ST_WRITE);
    assign go_wr      = s1_write && (s1_address == REG_GO);
    assign go_start   = go_wr && (s1_writedata != 32'd0) &&
                        ((state_q == ST_IDLE) || (state_q == ST_INTERRUPT));
    assign go_valid   = (count_q != 32'd0) && (count_q <= NS32) &&
                        (({1'b0, start_q} + {1'b0, count_q}) <= FRAME33);
    assign status_rd  = s1_read && (s1_address == REG_STATUS);
    assign status_clr = s1_write && (s1_address == REG_STATUS) && (s1_writedata == 32'd1);
    assign accept     = (state_q == ST_WRITE) && !m1_waitrequest;
    assign last_pixel = accept && ((progress_q + 32'd1) == count_q);

    pixel_addr_gen #(
        .H_RESOLUTION (H_RESOLUTION),
        .PIXEL_BYTES  (PIXEL_BYTES),
        .ROW_STRIDE   (ROW_STRIDE)
    ) u_addr_gen (
        .clock        (clock),
        .reset        (reset),
        .load_i       (go_start && go_valid),
        .base_i       (base_q),
        .start_i      (start_q),
        .step_i       (state_q == ST_SETUP),
        .advance_i    (accept),
        .setup_done_o (setup_done),
        .addr_o       (pix_addr)
    );

    // Next state, register-file updates and progress counting.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        start_d    = start_q;
        count_d    = count_q;
        progress_d = progress_q;

        if (s1_write && !busy) begin
            case (s1_address)
                REG_BASE:  base_d  = s1_writedata;
                REG_START: start_d = s1_writedata;
                REG_COUNT: count_d = s1_writedata;
                default:   ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (go_start) begin
                    state_d = go_valid ? ST_SETUP : ST_ERROR;
                end
            end
            ST_SETUP: begin
                if (go_wr) begin
                    state_d = ST_ERROR;
                end else if (setup_done) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (go_wr) begin
                    state_d = ST_ERROR;
                end else if (last_pixel) begin
                    state_d = ST_INTERRUPT;
                end
            end
            ST_INTERRUPT: begin
                // A new GO wins over the acknowledging STATUS read.
                if (go_start) begin
                    state_d = go_valid ? ST_SETUP : ST_ERROR;
                end else if (status_rd) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (status_clr) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (go_start && go_valid) begin
            progress_d = 32'd0;
        end else if (accept) begin
            progress_d = progress_q + 32'd1;
        end
    end

    // State and register file with synchronous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            start_q    <= '0;
            count_q    <= '0;
            progress_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            start_q    <= start_d;
            count_q    <= count_d;
            progress_q <= progress_d;
        end
    end

    // Bus-facing outputs: master active only in WRITE, slave reads combinational.
    always_comb begin
        s1_waitrequest = 1'b0;
        irq            = (state_q == ST_INTERRUPT);
        m1_write       = 1'b0;
        m1_address     = '0;
        m1_writedata   = '0;
        pix_index      = '0;
        if (state_q == ST_WRITE) begin
            m1_write     = 1'b1;
            m1_address   = pix_addr;
            m1_writedata = pix_data;
            pix_index    = progress_q[PIX_IDX_W-1:0];
        end

        case (s1_address)
            REG_BASE:     s1_readdata = base_q;
            REG_START:    s1_readdata = start_q;
            REG_COUNT:    s1_readdata = count_q;
            REG_PROGRESS: s1_readdata = progress_q;
            REG_STATUS: begin
                case (state_q)
                    ST_SETUP, ST_WRITE: s1_readdata = STATUS_BUSY;
                    ST_ERROR:           s1_readdata = STATUS_ERROR;
                    default:            s1_readdata = STATUS_IDLE;
                endcase
            end
            default:      s1_readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_pixel_writeback.sv
// Randomized bench for pixel_writeback with a frame-coordinate reference model.
module tb_pixel_writeback;
    import gpu_pkg::*;

    localparam int H   = 320;
    localparam int V   = 240;
    localparam int NS  = 320;
    localparam int PB  = 2;
    localparam int RS  = 1024;
    localparam int IDW = $clog2(NS);

    logic           clock;
    logic           reset;
    logic [3:0]     s1_address;
    logic           s1_read;
    logic           s1_write;
    logic [31:0]    s1_writedata;
    logic [31:0]    s1_readdata;
    logic           s1_waitrequest;
    logic           irq;
    logic [IDW-1:0] pix_index;
    logic [15:0]    pix_data;
    logic [31:0]    m1_address;
    logic [15:0]    m1_writedata;
    logic           m1_write;
    logic           m1_waitrequest;

    logic [15:0]    pix_mem [0:511];

    int n_checks = 0;
    int n_pass   = 0;

    assign pix_data = pix_mem[pix_index];

    pixel_writeback dut (
        .clock          (clock),
        .reset          (reset),
        .s1_address     (s1_address),
        .s1_read        (s1_read),
        .s1_write       (s1_write),
        .s1_writedata   (s1_writedata),
        .s1_readdata    (s1_readdata),
        .s1_waitrequest (s1_waitrequest),
        .irq            (irq),
        .pix_index      (pix_index),
        .pix_data       (pix_data),
        .m1_address     (m1_address),
        .m1_writedata   (m1_writedata),
        .m1_write       (m1_write),
        .m1_waitrequest (m1_waitrequest)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // All bus tasks start in the low clock phase and return at a falling edge.
    task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
        s1_address   = a;
        s1_writedata = d;
        s1_write     = 1'b1;
        @(negedge clock);
        s1_write     = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
        s1_address = a;
        s1_read    = 1'b1;
        #1;
        check_eq(tag, s1_readdata, exp);
        @(negedge clock);
        s1_read = 1'b0;
    endtask

    // Reference: pixel k of the frame lives at BASE + row*ROW_STRIDE + col*PIXEL_BYTES.
    function automatic logic [31:0] model_addr(input logic [31:0] base, input logic [31:0] lin);
        return base + (lin / H) * RS + (lin % H) * PB;
    endfunction

    // mode 0: never stall, 1: random stalls, 2: three stall cycles on pixel 2
    task automatic run_xfer(input int id, input logic [31:0] base, input logic [31:0] start,
                            input logic [31:0] count, input int mode);
        int i, cyc, first, stall_n, errs0;
        logic wr, prev_stall;
        logic [31:0] prev_addr;
        logic [15:0] prev_data;
        errs0 = n_checks - n_pass;
        for (int k = 0; k < 512; k++) pix_mem[k] = 16'($urandom);
        reg_write(REG_BASE, base);
        reg_write(REG_START, start);
        reg_write(REG_COUNT, count);
        reg_write(REG_GO, 32'd1);
        i = 0; cyc = 0; first = -1; stall_n = 0; prev_stall = 1'b0;
        prev_addr = '0; prev_data = '0;
        while (i < int'(count) && cyc < 2000) begin
            if (mode == 0)      wr = 1'b0;
            else if (mode == 1) wr = ($urandom_range(0, 3) == 0);
            else                wr = (i == 2) && (stall_n < 3);
            m1_waitrequest = wr;
            #1;
            if (cyc == 0) check_eq("setup_addr_zero", m1_address, 32'd0);
            if (prev_stall) begin
                check_eq("stall_addr", m1_address, prev_addr);
                check_eq("stall_data", {16'h0, m1_writedata}, {16'h0, prev_data});
            end
            if (m1_write) begin
                if (first < 0) begin
                    first = cyc;
                    check_eq("setup_latency", cyc, start / H + 1);
                end
                if (!wr) begin
                    check_eq("addr", m1_address, model_addr(base, start + i));
                    check_eq("pix_index", {23'h0, pix_index}, i);
                    check_eq("data", {16'h0, m1_writedata}, {16'h0, pix_mem[i]});
                    if (mode == 0) check_eq("consecutive", cyc, first + i);
                    i++;
                end else begin
                    stall_n++;
                end
                prev_stall = wr;
                prev_addr  = m1_address;
                prev_data  = m1_writedata;
            end else begin
                prev_stall = 1'b0;
            end
            @(negedge clock);
            cyc++;
        end
        if (cyc >= 2000) check_eq("xfer_timeout", 32'd0, 32'd1);
        m1_waitrequest = 1'b0;
        #1;
        check_eq("irq_after_last", irq, 1'b1);
        check_eq("m1_write_after_last", m1_write, 1'b0);
        read_check("progress", REG_PROGRESS, count);
        read_check("status_int", REG_STATUS, STATUS_IDLE);
        #1;
        check_eq("irq_cleared", irq, 1'b0);
        $display("txn %0d: base=%08h start=%0d count=%0d mode=%0d cycles=%0d new_errors=%0d",
                 id, base, start, count, mode, cyc, (n_checks - n_pass) - errs0);
    endtask

    task automatic error_case(input string tag, input logic [31:0] start, input logic [31:0] count);
        logic any_wr;
        reg_write(REG_START, start);
        reg_write(REG_COUNT, count);
        reg_write(REG_GO, 32'd1);
        any_wr = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            any_wr = any_wr | m1_write;
            @(negedge clock);
        end
        check_eq({tag, "_no_write"}, any_wr, 1'b0);
        read_check({tag, "_status"}, REG_STATUS, STATUS_ERROR);
        reg_write(REG_STATUS, 32'd1);
        read_check({tag, "_cleared"}, REG_STATUS, STATUS_IDLE);
        $display("txn err %s: start=%0d count=%0d", tag, start, count);
    endtask

    task automatic wait_for_write(input string tag);
        int c;
        c = 0;
        #1;
        while (!m1_write && c < 400) begin
            @(negedge clock);
            #1;
            c++;
        end
        if (c >= 400) check_eq(tag, 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] cnt, st;
        reset = 1'b1; s1_address = '0; s1_read = 1'b0; s1_write = 1'b0;
        s1_writedata = '0; m1_waitrequest = 1'b0;
        for (int k = 0; k < 512; k++) pix_mem[k] = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("rst_irq", irq, 1'b0);
        check_eq("rst_m1_write", m1_write, 1'b0);
        read_check("rst_status", REG_STATUS, STATUS_IDLE);
        read_check("rst_base", REG_BASE, 32'd0);
        read_check("rst_progress", REG_PROGRESS, 32'd0);
        read_check("unmapped", 4'h7, 32'd0);

        // Directed: linear start, row wrap, stall stability.
        run_xfer(0, 32'h0800_0000, 32'd0, 32'd4, 0);
        run_xfer(1, 32'h0800_0000, 32'd318, 32'd4, 0);
        run_xfer(2, 32'h0800_0000, 32'd640, 32'd4, 2);

        // Randomized passes across the frame.
        for (int t = 0; t < 8; t++) begin
            cnt = $urandom_range(1, NS);
            st  = $urandom_range(0, H * V - int'(cnt));
            run_xfer(3 + t, $urandom, st, cnt, 1);
        end
        // Last legal pixel of the frame.
        run_xfer(11, 32'h0000_1000, 32'd76798, 32'd2, 1);

        // Validation failures.
        error_case("count_zero", 32'd0, 32'd0);
        error_case("count_over", 32'd0, 32'(NS + 1));
        error_case("frame_over", 32'd76799, 32'd2);

        // GO while busy aborts; register writes while busy are ignored.
        reg_write(REG_BASE, 32'h0100_0000);
        reg_write(REG_START, 32'd5);
        reg_write(REG_COUNT, 32'd10);
        m1_waitrequest = 1'b1;
        reg_write(REG_GO, 32'd1);
        wait_for_write("busy_reach_write");
        @(negedge clock);
        reg_write(REG_COUNT, 32'd99);
        read_check("busy_count_kept", REG_COUNT, 32'd10);
        read_check("busy_status", REG_STATUS, STATUS_BUSY);
        reg_write(REG_GO, 32'd1);
        #1;
        check_eq("abort_m1_write", m1_write, 1'b0);
        read_check("abort_status", REG_STATUS, STATUS_ERROR);
        reg_write(REG_STATUS, 32'd1);
        read_check("abort_cleared", REG_STATUS, STATUS_IDLE);
        m1_waitrequest = 1'b0;
        $display("txn abort: GO during WRITE");

        // Reset in the middle of a stalled transfer.
        m1_waitrequest = 1'b1;
        reg_write(REG_GO, 32'd1);
        wait_for_write("rst_reach_write");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("midrst_m1_write", m1_write, 1'b0);
        check_eq("midrst_irq", irq, 1'b0);
        read_check("midrst_status", REG_STATUS, STATUS_IDLE);
        read_check("midrst_count", REG_COUNT, 32'd0);
        read_check("midrst_progress", REG_PROGRESS, 32'd0);
        m1_waitrequest = 1'b0;
        $display("txn reset: reset under waitrequest");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
